// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and parity mode constants shared by the UART receiver
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push at full is accepted only alongside a pop
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           i_push,
   input  logic                           i_pop,
   input  logic [WIDTH-1:0]               i_data,
   output logic [WIDTH-1:0]               o_data,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push, w_pop;

   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with input synchroniser, start-glitch rejection,
// per-word parity/framing flags and a receive FIFO with sticky overrun
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              rx,
   input  logic                              rd_en,
   input  logic                              clr_overrun,
   output logic [DATA_BITS-1:0]              rd_data,
   output logic                              rd_valid,
   output logic                              rd_parity_err,
   output logic                              rd_frame_err,
   output logic                              overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
   localparam int             CW     = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]  C_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0]  C_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]     B_LAST = 3'(DATA_BITS - 1);
   localparam logic           S_LAST = STOP_BITS == 2;

   uart_rx_state_t         r_state;
   logic                   r_sync1, r_sync2, r_armed, r_par_err, r_frame_err, r_stop, r_overrun;
   logic [CW-1:0]          r_cnt;
   logic [2:0]             r_bit;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   w_rx_s, w_tick, w_push, w_full, w_empty, w_drop, w_par_x;
   logic [DATA_BITS+1:0]   w_head;

   assign w_rx_s  = r_sync2;
   assign w_tick  = r_cnt == ((r_state == ST_START) ? C_HALF : C_LAST);
   assign w_push  = (r_state == ST_STOP) && w_tick && (r_stop == S_LAST);
   assign w_drop  = w_push && w_full && !rd_en;
   assign w_par_x = ^r_shift ^ w_rx_s;

   // armed tracks "line seen idle since reset or since the last frame ended"
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_armed     <= 1'b0;
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_stop      <= 1'b0;
         r_shift     <= '0;
         r_par_err   <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_sync1   <= rx;
         r_sync2   <= r_sync1;
         r_armed   <= w_push ? 1'b0 : (r_armed | w_rx_s);
         r_overrun <= w_drop ? 1'b1 : (clr_overrun ? 1'b0 : r_overrun);
         r_cnt     <= (r_state == ST_IDLE || w_tick) ? '0 : r_cnt + CW'(1);
         case (r_state)
            ST_IDLE:
               if (r_armed && !w_rx_s) begin
                  r_state     <= ST_START;
                  r_par_err   <= 1'b0;
                  r_frame_err <= 1'b0;
               end
            ST_START:
               if (w_tick) begin
                  r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                  r_bit   <= '0;
               end
            ST_DATA:
               if (w_tick) begin
                  r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit   <= r_bit + 3'd1;
                  r_stop  <= 1'b0;
                  if (r_bit == B_LAST) r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end
            ST_PARITY:
               if (w_tick) begin
                  r_par_err <= (PARITY == PARITY_EVEN) ? w_par_x : (PARITY == PARITY_ODD) && !w_par_x;
                  r_state   <= ST_STOP;
               end
            ST_STOP:
               if (w_tick) begin
                  r_frame_err <= r_frame_err | !w_rx_s;
                  r_stop      <= ~r_stop;
                  if (r_stop == S_LAST) r_state <= ST_IDLE;
               end
            default: r_state <= ST_IDLE;
         endcase
      end

   sync_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (rd_en),
      .i_data  ({r_frame_err | !w_rx_s, r_par_err, r_shift}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign {rd_frame_err, rd_parity_err, rd_data} = w_head;
   assign rd_valid = !w_empty;
   assign overrun  = r_overrun;

endmodule
